// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
//
// Fully pipelined N_CH-to-1 word multiplexer built as a registered binary tree
// of 2:1 stages. The sample is selected either manually from `sel` or by an
// internal scan pointer that walks the enabled channels of `ch_mask`.
// One sample per clock, no backpressure, fixed latency of SEL_W cycles.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_data    N_CH*WIDTH  channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   offer one sample this cycle
//   mode       0 = manual (sel), 1 = auto-scan (scan pointer)
//   sel        SEL_W  channel index used in manual mode
//   ch_mask    N_CH   channel enables used in scan mode
//   out_data   WIDTH  selected word
//   out_ch     SEL_W  channel index of out_data
//   out_valid  out_data / out_ch / out_last are valid
//   out_last   sample is the last enabled channel of a scan pass
//
// SEL_W must equal log2(N_CH); N_CH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module mux_tree_pipe #(
    parameter int N_CH  = 16,
    parameter int SEL_W = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       ch_mask,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    output logic                  out_last
);

    // -------------------------------------------------------------------------
    // Scan pointer and issue decision
    // -------------------------------------------------------------------------
    logic [SEL_W-1:0] scan_ptr_reg;
    logic [SEL_W-1:0] scan_ptr_next;
    logic [SEL_W-1:0] above_ptr;     // lowest set mask bit strictly above ptr
    logic [SEL_W-1:0] wrap_ptr;      // lowest set mask bit overall
    logic [SEL_W-1:0] cand_ptr;      // where the pointer goes if it advances
    logic             found_above;
    logic             any_set;
    logic             advance;
    logic             issue;
    logic             issue_last;
    logic [SEL_W-1:0] issue_idx;

    // Walking from the top bit down, the last hit is the lowest qualifying bit.
    always_comb begin
        above_ptr   = '0;
        wrap_ptr    = '0;
        found_above = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                wrap_ptr = SEL_W'(i);
                if (SEL_W'(i) > scan_ptr_reg) begin
                    above_ptr   = SEL_W'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

    assign any_set  = |ch_mask;
    assign cand_ptr = found_above ? above_ptr : wrap_ptr;

    // The pointer moves on every offered scan cycle, issued or dropped, so a
    // channel disabled under the pointer is skipped rather than stalling.
    assign advance       = mode & in_valid & any_set;
    assign scan_ptr_next = advance ? cand_ptr : scan_ptr_reg;

    assign issue      = in_valid & (~mode | ch_mask[scan_ptr_reg]);
    assign issue_idx  = mode ? scan_ptr_reg : sel;
    // A pass ends when the pointer wraps (or stays put with a single channel).
    assign issue_last = mode & (cand_ptr <= scan_ptr_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ptr_reg <= '0;
        end else begin
            scan_ptr_reg <= scan_ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Register tree. Stage 0 captures the issued sample (all inputs are frozen
    // there), stage k halves the word count using index bit k-1. Stage SEL_W
    // holds a single word and drives the outputs directly.
    // Data and index only load on a valid sample, so they hold while idle;
    // the last flag is qualified by valid so it reads 0 on idle cycles.
    // -------------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi <= SEL_W; gi++) begin : lvl
            localparam int NW = N_CH >> gi;

            logic [NW*WIDTH-1:0] data_reg;
            logic [SEL_W-1:0]    idx_reg;
            logic                valid_reg;
            logic                last_reg;

            if (gi == 0) begin : g_cap
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        data_reg  <= '0;
                        idx_reg   <= '0;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                    end else begin
                        valid_reg <= issue;
                        last_reg  <= issue & issue_last;
                        if (issue) begin
                            data_reg <= in_data;
                            idx_reg  <= issue_idx;
                        end
                    end
                end
            end else begin : g_mux
                logic [NW*WIDTH-1:0] data_next;

                for (gj = 0; gj < NW; gj++) begin : pair
                    assign data_next[gj*WIDTH +: WIDTH] =
                        lvl[gi-1].idx_reg[gi-1]
                            ? lvl[gi-1].data_reg[(2*gj+1)*WIDTH +: WIDTH]
                            : lvl[gi-1].data_reg[(2*gj)*WIDTH +: WIDTH];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        data_reg  <= '0;
                        idx_reg   <= '0;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                    end else begin
                        valid_reg <= lvl[gi-1].valid_reg;
                        last_reg  <= lvl[gi-1].valid_reg & lvl[gi-1].last_reg;
                        if (lvl[gi-1].valid_reg) begin
                            data_reg <= data_next;
                            idx_reg  <= lvl[gi-1].idx_reg;
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_data  = lvl[SEL_W].data_reg;
    assign out_ch    = lvl[SEL_W].idx_reg;
    assign out_valid = lvl[SEL_W].valid_reg;
    assign out_last  = lvl[SEL_W].last_reg;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_tree_pipe
//
// Directed stimulus for mux_tree_pipe (16 channels x 8 bits). Channel i always
// carries 8'hA0+i. Each driven vector states whether it should produce an
// output and with which channel / last flag; expected entries go into a queue
// with the edge number on which they must appear. A negedge monitor pops and
// compares whenever out_valid is high and checks idle-cycle behaviour.
// -----------------------------------------------------------------------------
module tb_mux_tree_pipe;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;
    localparam int WIDTH = 8;
    localparam int LAT   = 4;

    logic                  clk;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH-1:0]       ch_mask;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_last;

    mux_tree_pipe #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .mode      (mode),
        .sel       (sel),
        .ch_mask   (ch_mask),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] ch;
        logic             last;
        int               due;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    function automatic logic [N_CH*WIDTH-1:0] chan_words();
        logic [N_CH*WIDTH-1:0] w;
        for (int i = 0; i < N_CH; i++) w[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
        return w;
    endfunction

    // Drive one cycle of inputs; the sample is taken on the next rising edge.
    task automatic drive(input logic v, input logic m, input logic [SEL_W-1:0] s,
                         input logic [N_CH-1:0] mask, input logic ex,
                         input logic [SEL_W-1:0] ech, input logic elast);
        exp_t e;
        in_valid = v;
        mode     = m;
        sel      = s;
        ch_mask  = mask;
        if (ex) begin
            e.d    = 8'hA0 + {4'h0, ech};
            e.ch   = ech;
            e.last = elast;
            e.due  = edge_cnt + 1 + LAT;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic [WIDTH-1:0] prev_data = '0;
    logic [SEL_W-1:0] prev_ch   = '0;

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("out ch=%0d data=%0h last=%0d edge=%0d", out_ch, out_data, out_last, edge_cnt);
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_ch",   32'(out_ch),   32'(e.ch));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("latency",  32'(edge_cnt), 32'(e.due));
            end
        end else begin
            chk("idle_last", 32'(out_last), 32'd0);
            if (!rst) begin
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_ch",   32'(out_ch),   32'(prev_ch));
            end
        end
        prev_data = out_data;
        prev_ch   = out_ch;
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        rst      = 1'b1;
        in_data  = chan_words();
        in_valid = 1'b0;
        mode     = 1'b0;
        sel      = '0;
        ch_mask  = '0;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Manual single; inputs scrambled after issue must not leak through.
        drive(1'b1, 1'b0, 4'd5, 16'h0000, 1'b1, 4'd5, 1'b0);
        in_data = '1;
        idle(6);
        in_data = chan_words();

        // Manual stream 0..15 back to back.
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b0, 4'(i), 16'h0000, 1'b1, 4'(i), 1'b0);
        idle(6);

        // Scan with mask 8421 from pointer 0: 0,5,10,15 twice.
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1, 4'd0,  1'b0);
            drive(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1, 4'd5,  1'b0);
            drive(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1, 4'd10, 1'b0);
            drive(1'b1, 1'b1, 4'd0, 16'h8421, 1'b1, 4'd15, 1'b1);
        end
        idle(6);

        // Empty mask: nothing issued, pointer holds at 0.
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b1, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);
        idle(6);
        chk("empty_mask_ptr", 32'(dut.scan_ptr_reg), 32'd0);

        // Single enabled channel: every sample is channel 0 and last.
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b1, 4'd0, 16'h0001, 1'b1, 4'd0, 1'b1);
        idle(6);

        // Mask change mid-scan: walk 0..5 under 00FF, then clear bit 6 while
        // the pointer sits on it.
        for (int i = 0; i < 6; i++)
            drive(1'b1, 1'b1, 4'd0, 16'h00FF, 1'b1, 4'(i), 1'b0);
        drive(1'b1, 1'b1, 4'd0, 16'h00BF, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 4'd0, 16'h00BF, 1'b1, 4'd7, 1'b1);
        drive(1'b1, 1'b1, 4'd0, 16'h00BF, 1'b1, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 4'd0, 16'h00BF, 1'b1, 4'd1, 1'b0);
        // A manual sample in between leaves the scan pointer where it was.
        drive(1'b1, 1'b0, 4'd9, 16'h00BF, 1'b1, 4'd9, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 16'h00BF, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 4'd0, 16'h00BF, 1'b1, 4'd2, 1'b0);
        idle(6);

        // Reset with samples in flight.
        for (int i = 0; i < 6; i++)
            drive(1'b1, 1'b0, 4'(3 + i), 16'h0000, 1'b1, 4'(3 + i), 1'b0);
        #5;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data",  32'(out_data),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // After reset the scan restarts at channel 0.
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'(i), (i == 15) ? 1'b1 : 1'b0);
        idle(8);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, fully pipelined N-channel word multiplexer built as a registered binary tree of 2:1 stages. It has two selection modes: manual, where the select comes from a port, and auto-scan, where an internal pointer steps through the enabled channels and skips masked ones. It accepts one sample per clock with no backpressure and delivers the selected word, its channel index and an end-of-scan marker a fixed number of cycles later. It sits between a bank of parallel sources and a single serial consumer, for example a sample bus or a debug capture port.

## Interface
Parameters:
- N_CH, 16, number of channels; power of two, at least 2.
- SEL_W, 4, select width; must equal log2(N_CH).
- WIDTH, 8, data bits per channel.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- in_data  input  N_CH*WIDTH  channel words; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  1  issue one sample this cycle.
- mode  input  1  0 = manual (use sel), 1 = auto-scan (use internal pointer).
- sel  input  SEL_W  channel index used in manual mode.
- ch_mask  input  N_CH  channel enables used in scan mode only; bit i enables channel i.
- out_data  output  WIDTH  selected word.
- out_ch  output  SEL_W  channel index of out_data.
- out_valid  output  1  out_data, out_ch and out_last are valid.
- out_last  output  1  sample is the final enabled channel of a scan pass; always 0 in manual mode.

## Operation
- **Issue index.**
  - In manual mode the issue index is sel.
  - In scan mode the issue index is scan_ptr.
- **Issue condition.** A sample is issued when in_valid=1 and either mode=0, or mode=1 and ch_mask[scan_ptr]=1. Any other in_valid=1 cycle is dropped and produces no output.
- **Tree structure.**
  - The tree has SEL_W levels. Level k (k=1..SEL_W) uses index bit k-1 to choose between adjacent pairs from level k-1. Level 0 is the raw in_data.
  - Each level is registered.
  - The valid bit, full index and last flag travel alongside the data in every stage.
- **Scan pointer.**
  - scan_ptr is SEL_W bits and resets to 0.
  - In scan mode, on every in_valid=1 cycle (issued or dropped), scan_ptr moves to the next set bit of ch_mask strictly above its current value. If no such bit exists, it wraps to the lowest set bit. If only one bit is set, it returns to that same index.
  - If ch_mask=0, scan_ptr holds and nothing is issued.
  - scan_ptr holds in manual mode and when in_valid=0. Switching modes does not reset it.
- **End-of-scan flag.** The issued last flag is 1 when mode=1 and the computed next pointer is less than or equal to the current scan_ptr (a wrap occurs).
- **Mask changes.** ch_mask changes take effect on the same cycle they are presented. If scan_ptr points at a channel that has just been disabled, that in_valid cycle is dropped and the pointer advances.
- **Arithmetic.** Pointer arithmetic is modulo N_CH. There is no width extension: data passes through unmodified.

## Timing
- **Latency.** A sample issued on edge t appears on the outputs after edge t+SEL_W. Latency is exactly SEL_W cycles (4 for the defaults).
- **Throughput.** One sample per cycle, with no bubbles for back-to-back issues.
- **Sampling.** Every input (mode, sel, ch_mask, in_data) is sampled only on its issue cycle. Later changes do not affect samples already in flight.
- **Output registers.**
  - All outputs come directly from the final-level registers.
  - out_data and out_ch hold their last value while out_valid=0.
  - out_last is 0 whenever out_valid=0.
- **Reset values.** out_data=0, out_ch=0, out_valid=0, out_last=0, scan_ptr=0, and all stage valid bits are 0.
- **Reset mid-operation.** In-flight samples are discarded. out_valid falls asynchronously with rst. The first issue after rst deasserts appears SEL_W cycles after that issue.

## Test plan
- **Manual single.** N_CH=16, channel i word = 8'hA0+i, mode=0, sel=5, in_valid pulsed for one cycle at edge 10 → out_valid high only after edge 14, with out_data=A5, out_ch=5, out_last=0.
- **Manual stream.** sel=0..15 on consecutive cycles with in_valid held at 1 → 16 consecutive valid outputs A0..AF, out_ch 0..15, no gaps, starting 4 cycles after the first issue.
- **Scan with mask.** mode=1, ch_mask=16'h8421, in_valid held at 1 → out_ch sequence 0,5,10,15,0,5,… with out_last=1 only on channel 15.
- **Mask edge cases.**
  - ch_mask=0 for 20 cycles → out_valid stays 0 and scan_ptr stays 0.
  - Then ch_mask=16'h0001 → every output is channel 0 with out_last=1.
- **Mask change mid-scan.** ch_mask=16'h00FF with scan_ptr=6, then bit 6 cleared on that cycle → that cycle is dropped, and the next outputs are channels 7,0,1,….
- **Reset in flight.** Three samples issued, then rst pulsed 2 cycles later → out_valid falls immediately and none of the three samples emerge. After release in scan mode with ch_mask=16'hFFFF, the first output is channel 0.
